// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared types and defaults for the PLL lock / reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pll_seq_pkg;

    // Default qualification parameters, in refclk cycles
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_HOLD_CYCLES    = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_PLL_RST_CYCLES = 8;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned RELOCK_W   = 8;
    localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

    // Sequencer states; the encoding is visible on the debug state port
    typedef enum logic [STATE_W-1:0] {
        PLLRST = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        HOLD   = 3'd3,
        RUN    = 3'd4
    } pll_state_e;

    // Width that holds the largest cycle parameter without wrapping
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// Bundle of PLL control and system reset status signals around the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level indications.
interface pll_lock_reset_seq_if;
    import pll_seq_pkg::*;

    logic                pll_locked;
    logic                pll_rst;
    logic                sys_rst_n;
    logic                ready;
    logic [RELOCK_W-1:0] relock_cnt;
    logic [STATE_W-1:0]  state;

    // Sequencer side: consumes the lock indication, drives resets and status
    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output relock_cnt,
        output state
    );

    // PLL / system side: provides lock, observes resets and status
    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  relock_cnt,
        input  state
    );
endinterface

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_reset_seq.sv
// Sequences PLL reset, qualifies lock, then releases the system reset.
// Latency: sys_rst_n rises STABLE_CYCLES+HOLD_CYCLES+3 edges after lock is first sampled.
// Backpressure: none; lock loss in RUN re-asserts sys_rst_n within 3 edges.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
    input  logic refclk,
    input  logic rst_n,
    pll_lock_reset_seq_if.master bus
);
    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES,
                                              TIMEOUT_CYCLES, PLL_RST_CYCLES);

    // Terminal counts for each timed state
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic                locked_s;
    pll_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pll_rst_q;
    logic                sys_rst_n_q;
    logic                ready_q;
    logic [RELOCK_W-1:0] relock_q;

    // pll_locked comes from the PLL's own timing; only the resynchronized copy is used
    sync_2ff u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // Sequencer FSM with registered outputs; one shared counter times every state.
    // STABLE counts STABLE_CYCLES consecutive locked cycles and acts on the edge
    // after the count completes, so a drop on that last edge still disqualifies.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            relock_q    <= '0;
        end else begin
            case (state_q)
                PLLRST: begin
                    if (cnt_q == PLLRST_LAST) begin
                        state_q   <= WAIT;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WAIT: begin
                    if (locked_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= PLLRST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_DONE) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q     <= WAIT;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (relock_q != RELOCK_MAX) begin
                            relock_q <= relock_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= PLLRST;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.ready      = ready_q;
    assign bus.relock_cnt = relock_q;
    assign bus.state      = state_q;

endmodule
